// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes, flag bit positions, branch FSM states.
package cpu_pkg;

  localparam logic [3:0] COND_EQ     = 4'd0;
  localparam logic [3:0] COND_NE     = 4'd1;
  localparam logic [3:0] COND_LT     = 4'd2;
  localparam logic [3:0] COND_GE     = 4'd3;
  localparam logic [3:0] COND_LTU    = 4'd4;
  localparam logic [3:0] COND_GEU    = 4'd5;
  localparam logic [3:0] COND_ALWAYS = 4'd6;
  localparam logic [3:0] COND_NEVER  = 4'd7;

  // Flags are packed as {Z,N,C,V}.
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Sequential PC step for a not-taken branch.
  localparam int PC_INC = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESOLVE,
    ST_REDIRECT
  } br_state_e;

endpackage

// File: rtl/branch_unit_cond_eval.sv
// Combinational condition evaluator: {flags, cond} -> {taken, illegal}.
// Reserved codes resolve as not taken and raise illegal.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       taken,
  output logic       illegal
);

  // Decode the condition against the flag vector.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (cond)
      COND_EQ:     taken = flags[FLAG_Z];
      COND_NE:     taken = ~flags[FLAG_Z];
      COND_LT:     taken = flags[FLAG_N] ^ flags[FLAG_V];
      COND_GE:     taken = ~(flags[FLAG_N] ^ flags[FLAG_V]);
      COND_LTU:    taken = flags[FLAG_C];
      COND_GEU:    taken = ~flags[FLAG_C];
      COND_ALWAYS: taken = 1'b1;
      COND_NEVER:  taken = 1'b0;
      default:     illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Branch resolver: captures ALU flags, accepts one branch at a time,
// waits out in-flight flag writers, resolves and holds a PC redirect.
module branch_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flag_wr,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              flag_pending,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [3:0]        br_cond,
  input  logic [PC_W-1:0]   br_pc,
  input  logic [PC_W-1:0]   br_offset,
  output logic              redirect_valid,
  input  logic              redirect_ack,
  output logic              redirect_taken,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              illegal_cond,
  output logic [3:0]        flags,
  output logic [7:0]        stall_count
);

  br_state_e       state, state_nxt;
  logic [3:0]      req_cond;
  logic [PC_W-1:0] req_pc;
  logic [PC_W-1:0] req_offset;
  logic            eval_taken;
  logic            eval_illegal;

  cond_eval u_cond_eval (
    .flags   (flags),
    .cond    (req_cond),
    .taken   (eval_taken),
    .illegal (eval_illegal)
  );

  // Flag register tracks every ALU flag write regardless of FSM state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flags <= '0;
    end else if (flag_wr) begin
      flags[FLAG_Z] <= (alu_result == '0);
      flags[FLAG_N] <= alu_result[DATA_W-1];
      flags[FLAG_C] <= alu_carry;
      flags[FLAG_V] <= alu_overflow;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    br_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        br_ready = 1'b1;
        if (br_valid) state_nxt = flag_pending ? ST_WAIT : ST_RESOLVE;
      end
      ST_WAIT:     if (!flag_pending) state_nxt = ST_RESOLVE;
      ST_RESOLVE:  state_nxt = ST_REDIRECT;
      ST_REDIRECT: if (redirect_ack) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Request latch on acceptance.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_cond   <= '0;
      req_pc     <= '0;
      req_offset <= '0;
    end else if (state == ST_IDLE && br_valid) begin
      req_cond   <= br_cond;
      req_pc     <= br_pc;
      req_offset <= br_offset;
    end
  end

  // Resolve against the pre-edge flags; result held through REDIRECT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      redirect_taken <= 1'b0;
      redirect_pc    <= '0;
    end else if (state == ST_RESOLVE) begin
      redirect_taken <= eval_taken;
      redirect_pc    <= eval_taken ? req_pc + req_offset : req_pc + PC_W'(PC_INC);
    end
  end

  // Saturating count of cycles spent waiting on in-flight flag writers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                stall_count <= '0;
    else if (state == ST_WAIT && stall_count != 8'hFF) stall_count <= stall_count + 8'd1;
  end

  assign redirect_valid = (state == ST_REDIRECT);
  assign illegal_cond   = (state == ST_RESOLVE) && eval_illegal;

endmodule
